// File: rtl/counter_bcd_display_if.sv
// Count/display bus between the key/clock front end and the per-digit display decoders.
// Latency: none (wires only).
// Backpressure: none; bcd_valid is a one-cycle pulse and bcd/blank hold between pulses.
// Ports: en/up/load/load_val flow from master to slave; count, wrap, bcd, blank,
// bcd_valid, busy flow from slave to master.
interface counter_bcd_display_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) ();
    logic                  en;
    logic                  up;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      count;
    logic                  wrap;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  bcd_valid;
    logic                  busy;

    modport master (
        output en, up, load, load_val,
        input  count, wrap, bcd, blank, bcd_valid, busy
    );

    modport slave (
        input  en, up, load, load_val,
        output count, wrap, bcd, blank, bcd_valid, busy
    );
endinterface

// File: rtl/counter_bcd_display.sv
// Prescaled up/down modulus counter feeding a sequential double-dabble BCD converter.
// Latency: bcd follows a count change WIDTH+2 edges later when the converter is idle.
// Backpressure: none; count changes during a conversion are picked up by the next snapshot.
// Ports: CLOCK_50 (clock), reset (sync, active high), bus (slave side of counter_bcd_display_if).
module counter_bcd_display #(
    parameter int               WIDTH     = 16,
    parameter int               DIGITS    = 5,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1,
    parameter int               PRESCALE  = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    counter_bcd_display_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [WIDTH-1:0]  count_q;
    logic [PW-1:0]     pre_cnt;
    logic              wrap_q;
    logic              step;

    state_t            state;
    logic [WIDTH-1:0]  bin_sr;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     adj;
    logic [IW-1:0]     iter;
    logic [WIDTH-1:0]  last_conv;
    logic              first_pending;
    logic [SW-1:0]     bcd_q;
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_nxt;
    logic              bcd_valid_q;
    logic              busy_q;

    assign step = bus.en && (pre_cnt == PRE_LAST);

    // Counter: load beats step, and a load also restarts the prescaler.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_q <= '0;
            pre_cnt <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.load) begin
                count_q <= (bus.load_val > MAX_COUNT) ? MAX_COUNT : bus.load_val;
                pre_cnt <= '0;
            end else if (bus.en) begin
                pre_cnt <= step ? '0 : pre_cnt + 1'b1;
                if (step) begin
                    if (bus.up) begin
                        if (count_q == MAX_COUNT) begin
                            count_q <= '0;
                            wrap_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_q <= MAX_COUNT;
                            wrap_q  <= 1'b1;
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // A digit is blanked when it and every more significant digit are zero;
    // digit 0 always shows so a zero count still displays "0".
    always_comb begin
        logic run;
        run       = 1'b1;
        blank_nxt = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run          = run & (scratch[4*i +: 4] == 4'd0);
            blank_nxt[i] = run;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            bin_sr        <= '0;
            scratch       <= '0;
            iter          <= '0;
            last_conv     <= '0;
            first_pending <= 1'b1;
            bcd_q         <= '0;
            blank_q       <= ~(DIGITS'(1));
            bcd_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // first_pending forces one conversion after reset even though
                    // count and last_conv both read zero.
                    if (first_pending || (count_q != last_conv)) begin
                        bin_sr        <= count_q;
                        last_conv     <= count_q;
                        scratch       <= '0;
                        iter          <= '0;
                        first_pending <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {adj, bin_sr} << 1;
                    iter              <= iter + 1'b1;
                    if (iter == IW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_q       <= scratch;
                    blank_q     <= blank_nxt;
                    bcd_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.bcd       = bcd_q;
    assign bus.blank     = blank_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_counter_bcd_display.sv
// Bench for counter_bcd_display: dut0 uses default parameters, dut1 uses
// MAX_COUNT=9999, DIGITS=4, PRESCALE=4.
module tb_counter_bcd_display;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    counter_bcd_display_if #(.WIDTH(16), .DIGITS(5)) if0 ();
    counter_bcd_display_if #(.WIDTH(16), .DIGITS(4)) if1 ();

    counter_bcd_display #(.WIDTH(16), .DIGITS(5), .MAX_COUNT(16'hFFFF), .PRESCALE(1)) dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(if0));
    counter_bcd_display #(.WIDTH(16), .DIGITS(4), .MAX_COUNT(16'd9999), .PRESCALE(4)) dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(if1));

    // Reference state, one entry per DUT.
    int         m_count[2], m_pre[2], m_timer[2], m_snap[2], m_last[2];
    bit         m_wrap[2], m_valid[2], m_busy[2], m_first[2];
    logic [19:0] m_bcd[2];
    logic [4:0]  m_blank[2];

    function automatic int maxc(input int k); return (k == 0) ? 65535 : 9999; endfunction
    function automatic int prec(input int k); return (k == 0) ? 1 : 4;        endfunction
    function automatic int digc(input int k); return (k == 0) ? 5 : 4;        endfunction

    function automatic logic [19:0] to_bcd(input int v, input int d);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] blank_of(input int v, input int d);
        logic [4:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < d; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    // Conversion is modelled as a countdown of WIDTH+1 edges from the snapshot edge.
    task automatic model_step(input int k, input bit en, input bit up, input bit ld, input int lv);
        if (reset) begin
            m_count[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
            m_bcd[k] = '0; m_blank[k] = 5'b11110;
            m_valid[k] = 0; m_busy[k] = 0; m_timer[k] = 0; m_first[k] = 1; m_last[k] = 0;
        end else begin
            m_valid[k] = 0;
            if (m_timer[k] == 0) begin
                if (m_first[k] || m_count[k] != m_last[k]) begin
                    m_snap[k] = m_count[k]; m_last[k] = m_count[k];
                    m_first[k] = 0; m_timer[k] = 17; m_busy[k] = 1;
                end
            end else begin
                m_timer[k] = m_timer[k] - 1;
                if (m_timer[k] == 0) begin
                    m_bcd[k]   = to_bcd(m_snap[k], digc(k));
                    m_blank[k] = blank_of(m_snap[k], digc(k));
                    m_valid[k] = 1; m_busy[k] = 0;
                end
            end
            m_wrap[k] = 0;
            if (ld) begin
                m_count[k] = (lv > maxc(k)) ? maxc(k) : lv;
                m_pre[k] = 0;
            end else if (en) begin
                if (m_pre[k] == prec(k) - 1) begin
                    m_pre[k] = 0;
                    if (up) begin
                        if (m_count[k] == maxc(k)) begin m_count[k] = 0; m_wrap[k] = 1; end
                        else m_count[k] = m_count[k] + 1;
                    end else begin
                        if (m_count[k] == 0) begin m_count[k] = maxc(k); m_wrap[k] = 1; end
                        else m_count[k] = m_count[k] - 1;
                    end
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                end
            end
        end
    endtask

    // One clock: model consumes the inputs held since the last falling edge,
    // outputs are then observed on the falling edge.
    task automatic tick();
        @(posedge CLOCK_50);
        model_step(0, if0.en, if0.up, if0.load, int'(if0.load_val));
        model_step(1, if1.en, if1.up, if1.load, int'(if1.load_val));
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        int pulses, at;
        bit wrap_seen;
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (if0.count !== 16'd0)   begin n_errors++; $display("FAIL rst_count got %0d exp 0", if0.count); end
        n_checks++; if (if0.wrap !== 1'b0)     begin n_errors++; $display("FAIL rst_wrap got %0b exp 0", if0.wrap); end
        n_checks++; if (if0.bcd !== 20'h0)     begin n_errors++; $display("FAIL rst_bcd got %0h exp 0", if0.bcd); end
        n_checks++; if (if0.blank !== 5'b11110) begin n_errors++; $display("FAIL rst_blank got %0b exp 11110", if0.blank); end
        n_checks++; if (if0.bcd_valid !== 1'b0 || if0.busy !== 1'b0) begin
            n_errors++; $display("FAIL rst_flags got valid=%0b busy=%0b exp 0 0", if0.bcd_valid, if0.busy); end
        n_checks++; if (if1.blank !== 4'b1110) begin n_errors++; $display("FAIL rst_blank1 got %0b exp 1110", if1.blank); end
        reset = 1'b0;
        pulses = 0; at = -1; wrap_seen = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (if0.bcd_valid === 1'b1) begin pulses++; at = c; end
            if (if0.wrap !== 1'b0) wrap_seen = 1;
        end
        n_checks++; if (pulses != 1 || at != 18) begin n_errors++; $display("FAIL first_conv got pulses=%0d at=%0d exp 1 at 18", pulses, at); end
        n_checks++; if (if0.bcd !== 20'h0 || if0.blank !== 5'b11110) begin
            n_errors++; $display("FAIL first_bcd got %0h/%0b exp 0/11110", if0.bcd, if0.blank); end
        n_checks++; if (wrap_seen || if0.count !== 16'd0) begin
            n_errors++; $display("FAIL idle_count got wrap_seen=%0b count=%0d exp 0 0", wrap_seen, if0.count); end
    endtask

    task automatic test_load();
        if0.load = 1'b1; if0.load_val = 16'd12345;
        tick();
        if0.load = 1'b0;
        n_checks++; if (if0.count !== 16'd12345) begin n_errors++; $display("FAIL load_count got %0d exp 12345", if0.count); end
        for (int t = 1; t <= 18; t++) begin
            tick();
            n_checks++;
            if (if0.busy !== (t < 18) || if0.bcd_valid !== (t == 18)) begin
                n_errors++; $display("FAIL load_timing t=%0d got busy=%0b valid=%0b exp %0b %0b",
                                     t, if0.busy, if0.bcd_valid, t < 18, t == 18);
            end
        end
        n_checks++; if (if0.bcd !== 20'h12345 || if0.blank !== 5'b00000) begin
            n_errors++; $display("FAIL load_bcd got %0h/%0b exp 12345/00000", if0.bcd, if0.blank); end
        tick();
        n_checks++; if (if0.bcd_valid !== 1'b0 || if0.bcd !== 20'h12345) begin
            n_errors++; $display("FAIL load_hold got valid=%0b bcd=%0h exp 0 12345", if0.bcd_valid, if0.bcd); end
    endtask

    task automatic test_wrap();
        bit seen;
        if0.load = 1'b1; if0.load_val = 16'hFFFF;
        tick();
        if0.load = 1'b0;
        repeat (20) tick();
        if0.en = 1'b1; if0.up = 1'b1;
        tick();
        if0.en = 1'b0;
        n_checks++; if (if0.count !== 16'd0 || if0.wrap !== 1'b1) begin
            n_errors++; $display("FAIL wrap_up got count=%0d wrap=%0b exp 0 1", if0.count, if0.wrap); end
        seen = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1) begin
                n_checks++; if (if0.wrap !== 1'b0) begin n_errors++; $display("FAIL wrap_pulse got %0b exp 0", if0.wrap); end
            end
            if (if0.bcd_valid === 1'b1) seen = 1;
        end
        n_checks++; if (!seen || if0.bcd !== 20'h0 || if0.blank !== 5'b11110) begin
            n_errors++; $display("FAIL wrap_up_bcd got seen=%0b %0h/%0b exp 1 0/11110", seen, if0.bcd, if0.blank); end
        if0.en = 1'b1; if0.up = 1'b0;
        tick();
        if0.en = 1'b0;
        n_checks++; if (if0.count !== 16'hFFFF || if0.wrap !== 1'b1) begin
            n_errors++; $display("FAIL wrap_down got count=%0d wrap=%0b exp 65535 1", if0.count, if0.wrap); end
        seen = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (if0.bcd_valid === 1'b1) seen = 1;
        end
        n_checks++; if (!seen || if0.bcd !== 20'h65535 || if0.blank !== 5'b00000) begin
            n_errors++; $display("FAIL wrap_down_bcd got seen=%0b %0h/%0b exp 1 65535/00000", seen, if0.bcd, if0.blank); end
    endtask

    task automatic test_modulus();
        bit seen;
        if1.load = 1'b1; if1.load_val = 16'd12000;
        tick();
        if1.load = 1'b0;
        n_checks++; if (if1.count !== 16'd9999) begin n_errors++; $display("FAIL mod_clamp got %0d exp 9999", if1.count); end
        seen = 0;
        for (int c = 1; c <= 25; c++) begin tick(); if (if1.bcd_valid === 1'b1) seen = 1; end
        n_checks++; if (!seen || if1.bcd !== 16'h9999 || if1.blank !== 4'b0000) begin
            n_errors++; $display("FAIL mod_bcd got seen=%0b %0h/%0b exp 1 9999/0000", seen, if1.bcd, if1.blank); end
        if1.en = 1'b1; if1.up = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (if1.count !== 16'd9999) begin n_errors++; $display("FAIL mod_prestep got %0d exp 9999", if1.count); end
        tick();
        if1.en = 1'b0;
        n_checks++; if (if1.count !== 16'd0 || if1.wrap !== 1'b1) begin
            n_errors++; $display("FAIL mod_wrap got count=%0d wrap=%0b exp 0 1", if1.count, if1.wrap); end
        seen = 0;
        for (int c = 1; c <= 25; c++) begin tick(); if (if1.bcd_valid === 1'b1) seen = 1; end
        n_checks++; if (!seen || if1.bcd !== 16'h0 || if1.blank !== 4'b1110) begin
            n_errors++; $display("FAIL mod_zero_bcd got seen=%0b %0h/%0b exp 1 0/1110", seen, if1.bcd, if1.blank); end
        // Prescaler is one enabled cycle short of a step when the load arrives.
        if1.en = 1'b1;
        tick(); tick(); tick();
        if1.load = 1'b1; if1.load_val = 16'd77;
        tick();
        if1.load = 1'b0;
        n_checks++; if (if1.count !== 16'd77 || if1.wrap !== 1'b0) begin
            n_errors++; $display("FAIL load_vs_step got count=%0d wrap=%0b exp 77 0", if1.count, if1.wrap); end
        tick(); tick(); tick();
        n_checks++; if (if1.count !== 16'd77) begin n_errors++; $display("FAIL load_pre_clear got %0d exp 77", if1.count); end
        tick();
        if1.en = 1'b0;
        n_checks++; if (if1.count !== 16'd78) begin n_errors++; $display("FAIL load_pre_step got %0d exp 78", if1.count); end
    endtask

    task automatic test_prescale();
        if1.load = 1'b1; if1.load_val = 16'd0;
        tick();
        if1.load = 1'b0; if1.en = 1'b1; if1.up = 1'b1;
        repeat (12) tick();
        if1.en = 1'b0;
        n_checks++; if (if1.count !== 16'd3) begin n_errors++; $display("FAIL pre_12 got %0d exp 3", if1.count); end
        if1.en = 1'b1; repeat (2) tick();
        if1.en = 1'b0; repeat (5) tick();
        n_checks++; if (if1.count !== 16'd3) begin n_errors++; $display("FAIL pre_hold got %0d exp 3", if1.count); end
        if1.en = 1'b1; repeat (2) tick();
        if1.en = 1'b0;
        n_checks++; if (if1.count !== 16'd4) begin n_errors++; $display("FAIL pre_resume got %0d exp 4", if1.count); end
    endtask

    task automatic test_back_to_back();
        int last_at, nvalid, at;
        logic [19:0] prev;
        bit have_prev, seen_busy;
        if0.load = 1'b1; if0.load_val = 16'd0;
        tick();
        if0.load = 1'b0;
        repeat (20) tick();
        if0.en = 1'b1; if0.up = 1'b1;
        last_at = -1; nvalid = 0; have_prev = 0; prev = '0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            n_checks++; if (if0.count !== 16'(m_count[0])) begin
                n_errors++; $display("FAIL b2b_count got %0d exp %0d", if0.count, m_count[0]); end
            if (if0.bcd_valid === 1'b1) begin
                nvalid++;
                n_checks++; if (last_at >= 0 && c - last_at != 18) begin
                    n_errors++; $display("FAIL b2b_period got %0d exp 18", c - last_at); end
                n_checks++; if (if0.bcd !== m_bcd[0]) begin
                    n_errors++; $display("FAIL b2b_bcd got %0h exp %0h", if0.bcd, m_bcd[0]); end
                n_checks++; if (have_prev && if0.bcd <= prev) begin
                    n_errors++; $display("FAIL b2b_mono got %0h exp above %0h", if0.bcd, prev); end
                prev = if0.bcd; have_prev = 1; last_at = c;
            end
        end
        n_checks++; if (nvalid < 10) begin n_errors++; $display("FAIL b2b_pulses got %0d exp >=10", nvalid); end
        seen_busy = 0;
        for (int c = 0; c < 20 && !seen_busy; c++) begin tick(); if (if0.busy === 1'b1) seen_busy = 1; end
        n_checks++; if (!seen_busy) begin n_errors++; $display("FAIL b2b_busy got 0 exp 1"); end
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; if0.en = 1'b0;
        n_checks++; if (if0.busy !== 1'b0 || if0.bcd !== 20'h0 || if0.count !== 16'd0 || if0.blank !== 5'b11110) begin
            n_errors++; $display("FAIL abort got busy=%0b bcd=%0h count=%0d blank=%0b exp 0 0 0 11110",
                                 if0.busy, if0.bcd, if0.count, if0.blank); end
        at = -1;
        for (int c = 1; c <= 25; c++) begin tick(); if (if0.bcd_valid === 1'b1 && at < 0) at = c; end
        n_checks++; if (at != 18 || if0.bcd !== 20'h0) begin
            n_errors++; $display("FAIL abort_reconv got at=%0d bcd=%0h exp 18 0", at, if0.bcd); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            if0.load     = ($urandom_range(0, 15) == 0);
            if0.load_val = 16'($urandom);
            if0.en       = ($urandom_range(0, 3) != 0);
            if0.up       = ($urandom_range(0, 2) != 0);
            if1.load     = ($urandom_range(0, 15) == 0);
            if1.load_val = (($urandom & 1) != 0) ? 16'($urandom) : 16'($urandom_range(9980, 9999));
            if1.en       = ($urandom_range(0, 3) != 0);
            if1.up       = ($urandom_range(0, 2) == 0);
            tick();
            n_checks++; if (if0.count !== 16'(m_count[0]) || if0.wrap !== m_wrap[0]) begin
                n_errors++; $display("FAIL rnd_cnt0 got %0d/%0b exp %0d/%0b", if0.count, if0.wrap, m_count[0], m_wrap[0]); end
            n_checks++; if (if0.bcd !== m_bcd[0] || if0.blank !== m_blank[0]) begin
                n_errors++; $display("FAIL rnd_bcd0 got %0h/%0b exp %0h/%0b", if0.bcd, if0.blank, m_bcd[0], m_blank[0]); end
            n_checks++; if (if0.bcd_valid !== m_valid[0] || if0.busy !== m_busy[0]) begin
                n_errors++; $display("FAIL rnd_flag0 got %0b/%0b exp %0b/%0b", if0.bcd_valid, if0.busy, m_valid[0], m_busy[0]); end
            n_checks++; if (if1.count !== 16'(m_count[1]) || if1.wrap !== m_wrap[1]) begin
                n_errors++; $display("FAIL rnd_cnt1 got %0d/%0b exp %0d/%0b", if1.count, if1.wrap, m_count[1], m_wrap[1]); end
            n_checks++; if (if1.bcd !== m_bcd[1][15:0] || if1.blank !== m_blank[1][3:0]) begin
                n_errors++; $display("FAIL rnd_bcd1 got %0h/%0b exp %0h/%0b", if1.bcd, if1.blank, m_bcd[1][15:0], m_blank[1][3:0]); end
            n_checks++; if (if1.bcd_valid !== m_valid[1] || if1.busy !== m_busy[1]) begin
                n_errors++; $display("FAIL rnd_flag1 got %0b/%0b exp %0b/%0b", if1.bcd_valid, if1.busy, m_valid[1], m_busy[1]); end
        end
        reset = 1'b0;
        if0.load = 1'b0; if0.en = 1'b0; if1.load = 1'b0; if1.en = 1'b0;
    endtask

    initial begin
        if0.en = 1'b0; if0.up = 1'b1; if0.load = 1'b0; if0.load_val = '0;
        if1.en = 1'b0; if1.up = 1'b1; if1.load = 1'b0; if1.load_val = '0;
        @(negedge CLOCK_50);
        test_reset();
        test_load();
        test_wrap();
        test_modulus();
        test_prescale();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
